vga_enh_top_wrap: RTL and testbench



---
 rtl/vga_enh_top_wrap.sv | 246 ++++++++++++++++++++++++
 tb/tb_vga_enh_top_wrap.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_enh_top_wrap.sv
// vga_enh_top_wrap
// Single-clock VGA/LCD controller. A Wishbone slave register file holds the
// configuration. A Wishbone master fetches 24-bit pixels into a small FIFO,
// and a timing generator drives the FIFO contents out as RGB with
// hsync/vsync/blank.
// Ports:
//   wb_clk, wb_rst         : clock, asynchronous active-high reset
//   wbs_*                  : slave register interface (ack/err one cycle after stb&cyc)
//   wbm_*                  : master read interface (single classic reads)
//   wb_inta_o              : level interrupt (vsync / underrun)
//   hsync/vsync/blank_pad_o: sync outputs after the polarity XOR
//   r/g/b_pad_o            : pixel colour
module vga_enh_top_wrap #(
  parameter int PIX_DIV    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [11:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic [31:0] wbm_adr_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel_o,
  output logic [2:0]  wbm_cti_o,
  output logic        wbm_we_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        wb_inta_o,
  output logic        hsync_pad_o,
  output logic        vsync_pad_o,
  output logic        blank_pad_o,
  output logic [7:0]  r_pad_o,
  output logic [7:0]  g_pad_o,
  output logic [7:0]  b_pad_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(PIX_DIV);

  // ---------------- slave register file ----------------
  logic [31:0] ctrl_q, htim_q, vtim_q, hvlen_q, vbara_q, wbs_dat_q, rd_mux;
  logic        sint_q, vint_q, sint_d, vint_d, wbs_ack_q, wbs_err_q;
  logic        req, adr_ok, wr, frame_start, underrun;
  logic [2:0]  reg_idx;
  logic        ven, vie, sie, hpol, vpol, bpol;

  assign {bpol, vpol, hpol} = ctrl_q[6:4];
  assign {sie, vie, ven}    = ctrl_q[2:0];

  // Reject the cycle after ack/err so a held strobe yields one-cycle terminations.
  assign req     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_q & ~wbs_err_q;
  assign adr_ok  = (wbs_adr_i[11:2] <= 10'd5);
  assign reg_idx = wbs_adr_i[4:2];
  assign wr      = req & adr_ok & wbs_we_i;

  always_comb begin
    rd_mux = 32'd0;
    case (reg_idx)
      3'd0:    rd_mux = ctrl_q;
      3'd1:    rd_mux = {30'd0, vint_q, sint_q};
      3'd2:    rd_mux = htim_q;
      3'd3:    rd_mux = vtim_q;
      3'd4:    rd_mux = hvlen_q;
      3'd5:    rd_mux = vbara_q;
      default: rd_mux = 32'd0;
    endcase
  end

  // Write-1-clear, with a same-cycle set event taking priority.
  assign sint_d = (sint_q & ~(wr && reg_idx == 3'd1 && wbs_dat_i[0])) | underrun;
  assign vint_d = (vint_q & ~(wr && reg_idx == 3'd1 && wbs_dat_i[1])) | frame_start;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      ctrl_q <= '0; htim_q <= '0; vtim_q <= '0; hvlen_q <= '0; vbara_q <= '0;
      sint_q <= 1'b0; vint_q <= 1'b0;
      wbs_ack_q <= 1'b0; wbs_err_q <= 1'b0; wbs_dat_q <= '0;
    end else begin
      wbs_ack_q <= req & adr_ok;
      wbs_err_q <= req & ~adr_ok;
      wbs_dat_q <= (req & adr_ok) ? rd_mux : 32'd0;
      sint_q    <= sint_d;
      vint_q    <= vint_d;
      if (wr) begin
        case (reg_idx)
          3'd0:    ctrl_q  <= wbs_dat_i;
          3'd2:    htim_q  <= wbs_dat_i;
          3'd3:    vtim_q  <= wbs_dat_i;
          3'd4:    hvlen_q <= wbs_dat_i;
          3'd5:    vbara_q <= {wbs_dat_i[31:2], 2'b00};
          default: ;
        endcase
      end
    end
  end

  // ---------------- timing generator ----------------
  logic [DW-1:0] pdiv_q;
  logic [15:0]   hcnt_q, vcnt_q;
  logic          pix_en, visible;
  logic [1:0]    sync_raw, vis_raw;

  assign pix_en = ven & (pdiv_q == DW'(PIX_DIV - 1));

  // Index 0 is the horizontal axis (pixels), index 1 the vertical axis (lines).
  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    logic [31:0] tim;
    logic [16:0] cnt, sync_end, vis_beg, vis_end;
    assign tim      = (gi == 0) ? htim_q : vtim_q;
    assign cnt      = 17'((gi == 0) ? hcnt_q : vcnt_q);
    assign sync_end = 17'(tim[31:24]) + 17'd1;
    assign vis_beg  = sync_end + 17'(tim[23:16]) + 17'd1;
    assign vis_end  = vis_beg + 17'(tim[15:0]) + 17'd1;
    assign sync_raw[gi] = (cnt < sync_end);
    assign vis_raw[gi]  = (cnt >= vis_beg) && (cnt < vis_end);
  end

  assign visible     = &vis_raw;
  assign frame_start = pix_en & (hcnt_q == 16'd0) & (vcnt_q == 16'd0);

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      pdiv_q <= '0; hcnt_q <= '0; vcnt_q <= '0;
    end else if (!ven) begin
      pdiv_q <= '0; hcnt_q <= '0; vcnt_q <= '0;
    end else begin
      pdiv_q <= pix_en ? '0 : pdiv_q + DW'(1);
      if (pix_en) begin
        // >= rather than == so a shrunk total while running still wraps.
        if (hcnt_q >= hvlen_q[31:16]) begin
          hcnt_q <= '0;
          vcnt_q <= (vcnt_q >= hvlen_q[15:0]) ? 16'd0 : vcnt_q + 16'd1;
        end else begin
          hcnt_q <= hcnt_q + 16'd1;
        end
      end
    end
  end

  // ---------------- pixel FIFO ----------------
  logic [23:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fcnt_q;
  logic          push, pop, flush, fifo_empty, fifo_room;
  logic [23:0]   push_data;

  assign fifo_empty = (fcnt_q == '0);
  assign fifo_room  = (fcnt_q < (AW+1)'(FIFO_DEPTH));
  assign flush      = ~ven | frame_start;
  assign pop        = pix_en & visible & ~fifo_empty;
  assign underrun   = pix_en & visible & fifo_empty;

  always_ff @(posedge wb_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      wr_ptr_q <= '0; rd_ptr_q <= '0; fcnt_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0; rd_ptr_q <= '0; fcnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      fcnt_q <= fcnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // ---------------- fetch engine ----------------
  logic        cyc_q, discard_q, term;
  logic [31:0] adr_q, rem_q, rem_init;

  assign term      = cyc_q & (wbm_ack_i | wbm_err_i);
  assign push      = term & ~discard_q & ven;
  assign push_data = wbm_ack_i ? wbm_dat_i[23:0] : 24'd0;
  assign rem_init  = (32'(htim_q[15:0]) + 32'd1) * (32'(vtim_q[15:0]) + 32'd1);

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      cyc_q <= 1'b0; discard_q <= 1'b0; adr_q <= '0; rem_q <= '0;
    end else begin
      if (cyc_q) begin
        if (term) begin
          cyc_q     <= 1'b0;
          discard_q <= 1'b0;
          if (!discard_q) begin
            adr_q <= adr_q + 32'd4;
            rem_q <= rem_q - 32'd1;
          end
        end
      end else if (ven && rem_q != 32'd0 && fifo_room) begin
        cyc_q <= 1'b1;
      end
      // A read still outstanding at frame start belongs to the old frame:
      // let it complete on the bus but drop its data and bookkeeping.
      if (frame_start) begin
        adr_q     <= vbara_q;
        rem_q     <= rem_init;
        discard_q <= cyc_q & ~term;
      end
    end
  end

  // ---------------- display outputs ----------------
  logic hs_q, vs_q, bl_q;
  logic [23:0] rgb_q;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      hs_q <= 1'b0; vs_q <= 1'b0; bl_q <= 1'b0; rgb_q <= '0;
    end else if (!ven) begin
      hs_q <= hpol; vs_q <= vpol; bl_q <= bpol; rgb_q <= '0;
    end else if (pix_en) begin
      hs_q  <= sync_raw[0] ^ hpol;
      vs_q  <= sync_raw[1] ^ vpol;
      bl_q  <= ~visible ^ bpol;
      rgb_q <= pop ? fifo_mem[rd_ptr_q] : 24'd0;
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, wbs_sel_i, wbs_adr_i[1:0], wbm_dat_i[31:24]};

  assign wbs_dat_o   = wbs_dat_q;
  assign wbs_ack_o   = wbs_ack_q;
  assign wbs_err_o   = wbs_err_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_sel_o   = 4'hF;
  assign wbm_cti_o   = 3'b000;
  assign wbm_we_o    = 1'b0;
  assign wbm_stb_o   = cyc_q;
  assign wbm_cyc_o   = cyc_q;
  assign wb_inta_o   = (vint_q & vie) | (sint_q & sie);
  assign hsync_pad_o = hs_q;
  assign vsync_pad_o = vs_q;
  assign blank_pad_o = bl_q;
  assign {r_pad_o, g_pad_o, b_pad_o} = rgb_q;
endmodule

// File: tb/tb_vga_enh_top_wrap.sv
// Directed testbench for vga_enh_top_wrap: register access, a small 12x12
// display mode, polarity, underrun and vsync interrupts, reset during a read.
module tb_vga_enh_top_wrap;
  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b0;
  logic [11:0] wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic [31:0] wbs_dat_o;
  logic [3:0]  wbs_sel_i = 4'hF;
  logic        wbs_we_i = 1'b0, wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0;
  logic        wbs_ack_o, wbs_err_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_i = '0;
  logic [3:0]  wbm_sel_o;
  logic [2:0]  wbm_cti_o;
  logic        wbm_we_o, wbm_stb_o, wbm_cyc_o;
  logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0;
  logic        wb_inta_o, hsync_pad_o, vsync_pad_o, blank_pad_o;
  logic [7:0]  r_pad_o, g_pad_o, b_pad_o;

  int n_checks = 0;
  int n_errors = 0;
  int mem_delay = 0;
  localparam logic [31:0] MEM_BASE = 32'h0000_1000;
  localparam int FRAME_CLKS = 12 * 12 * 4;

  vga_enh_top_wrap #(.PIX_DIV(4), .FIFO_DEPTH(16)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
    .wbs_sel_i(wbs_sel_i), .wbs_we_i(wbs_we_i), .wbs_stb_i(wbs_stb_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_i(wbm_dat_i), .wbm_sel_o(wbm_sel_o),
    .wbm_cti_o(wbm_cti_o), .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .wb_inta_o(wb_inta_o), .hsync_pad_o(hsync_pad_o), .vsync_pad_o(vsync_pad_o),
    .blank_pad_o(blank_pad_o), .r_pad_o(r_pad_o), .g_pad_o(g_pad_o), .b_pad_o(b_pad_o)
  );

  always #5 wb_clk = ~wb_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Memory model: acks after mem_delay wait cycles, data = word index with junk in [31:24].
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge wb_clk); #1;
      if (wb_rst) begin
        wbm_ack_i = 1'b0; wait_cnt = 0;
      end else if (wbm_ack_i) begin
        wbm_ack_i = 1'b0;
      end else if (wbm_cyc_o && wbm_stb_o) begin
        if (wait_cnt >= mem_delay) begin
          wbm_dat_i = {8'hAB, 24'((wbm_adr_o - MEM_BASE) >> 2)};
          wbm_ack_i = 1'b1;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", tag, obs, exp);
    end
  endtask

  task automatic wbs_xfer(input logic [11:0] a, input logic we, input logic [31:0] d,
                          output logic [31:0] rd, output logic ack, output logic err,
                          output int lat);
    @(negedge wb_clk);
    wbs_adr_i = a; wbs_we_i = we; wbs_dat_i = d; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    lat = -1; ack = 1'b0; err = 1'b0; rd = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge wb_clk);
      if (wbs_ack_o || wbs_err_o) begin
        lat = i; ack = wbs_ack_o; err = wbs_err_o; rd = wbs_dat_o;
        break;
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    $display("wbs %s adr=%h wdat=%h rdat=%h ack=%0b err=%0b lat=%0d",
             we ? "wr" : "rd", a, d, rd, ack, err, lat);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] rd; logic ack, err; int lat;
    wbs_xfer(a, 1'b1, d, rd, ack, err, lat);
    check("wr_ack_latency", lat, 1);
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    logic ack, err; int lat;
    wbs_xfer(a, 1'b0, 32'd0, d, ack, err, lat);
    check("rd_ack", ack, 1'b1);
  endtask

  task automatic do_reset();
    wb_rst = 1'b1;
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b0;
    @(negedge wb_clk);
  endtask

  // Small mode: 2/2/4 horizontally and vertically, 12x12 totals.
  task automatic setup(input logic [31:0] ctrl, input int delay);
    mem_delay = delay;
    do_reset();
    wr(12'h008, 32'h0101_0003);
    wr(12'h00C, 32'h0101_0003);
    wr(12'h010, 32'h000B_000B);
    wr(12'h014, MEM_BASE);
    wr(12'h000, ctrl);
  endtask

  // Finds the next active vsync edge and measures one whole frame.
  task automatic check_frame(input logic pol, input string tag);
    int hs_clk, vs_clk, pix, rgb_bad, acks, hs_run;
    logic found, prev, cur, hs, vs, bl, run_open;
    logic [31:0] first_adr;
    hs_clk = 0; vs_clk = 0; pix = 0; rgb_bad = 0; acks = 0; hs_run = 0;
    found = 1'b0; run_open = 1'b1; first_adr = '1;
    prev = vsync_pad_o ^ pol;
    for (int i = 0; i < 2000; i++) begin
      @(negedge wb_clk);
      cur = vsync_pad_o ^ pol;
      if (cur && !prev) begin found = 1'b1; break; end
      prev = cur;
    end
    check({tag, "_vsync_found"}, found, 1'b1);
    if (!found) return;
    for (int c = 0; c < FRAME_CLKS; c++) begin
      if (c > 0) @(negedge wb_clk);
      hs = hsync_pad_o ^ pol; vs = vsync_pad_o ^ pol; bl = blank_pad_o ^ pol;
      if (hs) hs_clk++;
      if (vs) vs_clk++;
      if (run_open && hs) hs_run++; else run_open = 1'b0;
      if (!bl) begin
        check({tag, "_rgb"}, {8'd0, r_pad_o, g_pad_o, b_pad_o}, 32'(pix / 4));
        pix++;
      end else if ({r_pad_o, g_pad_o, b_pad_o} != 24'd0) begin
        rgb_bad++;
      end
      if (wbm_ack_i) begin
        if (acks == 0) first_adr = wbm_adr_o;
        acks++;
      end
    end
    check({tag, "_hsync_first_run"}, hs_run, 8);
    check({tag, "_hsync_clks"}, hs_clk, 96);
    check({tag, "_vsync_clks"}, vs_clk, 96);
    check({tag, "_visible_clks"}, pix, 64);
    check({tag, "_rgb_in_blank"}, rgb_bad, 0);
    check({tag, "_fetch_count"}, acks, 16);
    check({tag, "_first_fetch_adr"}, first_adr, MEM_BASE);
  endtask

  initial begin
    logic [31:0] d;
    logic ack, err, found;
    int lat;

    // Reset state
    do_reset();
    check("rst_outputs", {wbm_cyc_o, wbm_stb_o, wb_inta_o, hsync_pad_o, vsync_pad_o,
                          blank_pad_o, wbs_ack_o, wbs_err_o}, 8'd0);
    check("rst_rgb", {r_pad_o, g_pad_o, b_pad_o}, 24'd0);
    check("rst_wbm_adr", wbm_adr_o, 32'd0);
    check("wbm_consts", {wbm_sel_o, wbm_cti_o, wbm_we_o}, {4'hF, 3'b000, 1'b0});
    rd(12'h004, d); check("rst_stat", d, 32'd0);

    // Register access
    wr(12'h000, 32'h0000_0072); rd(12'h000, d); check("rb_ctrl", d, 32'h0000_0072);
    wr(12'h008, 32'h0304_0027); rd(12'h008, d); check("rb_htim", d, 32'h0304_0027);
    wr(12'h00C, 32'h0506_0013); rd(12'h00C, d); check("rb_vtim", d, 32'h0506_0013);
    wr(12'h010, 32'h0031_0021); rd(12'h010, d); check("rb_hvlen", d, 32'h0031_0021);
    wr(12'h014, 32'h1234_5677); rd(12'h014, d); check("rb_vbara", d, 32'h1234_5674);
    wr(12'h004, 32'hFFFF_FFFF); rd(12'h004, d); check("rb_stat_ro", d, 32'd0);
    // VEN=0 with all polarities set: outputs sit at inactive level
    repeat (3) @(negedge wb_clk);
    check("ven0_pads", {hsync_pad_o, vsync_pad_o, blank_pad_o}, 3'b111);
    check("ven0_rgb", {r_pad_o, g_pad_o, b_pad_o}, 24'd0);
    check("ven0_cyc", wbm_cyc_o, 1'b0);
    wbs_xfer(12'h018, 1'b0, 32'd0, d, ack, err, lat);
    check("bad_adr_err", err, 1'b1);
    check("bad_adr_ack", ack, 1'b0);
    check("bad_adr_dat", d, 32'd0);

    // Small mode, normal polarity
    setup(32'h0000_0001, 0);
    check_frame(1'b0, "small");

    // Inverted polarity
    setup(32'h0000_0071, 0);
    check_frame(1'b1, "pol");

    // Underrun with a slow memory
    setup(32'h0000_0005, 40);
    repeat (700) @(negedge wb_clk);
    rd(12'h004, d); check("underrun_sint", d & 32'd1, 32'd1);
    check("underrun_inta", wb_inta_o, 1'b1);
    wr(12'h000, 32'h0000_0004);
    wr(12'h004, 32'h0000_0000);
    rd(12'h004, d); check("stat_wr0_noeffect", d & 32'd1, 32'd1);
    wr(12'h004, 32'h0000_0001);
    rd(12'h004, d); check("stat_w1c_sint", d & 32'd1, 32'd0);
    check("underrun_inta_cleared", wb_inta_o, 1'b0);

    // Vsync interrupt
    setup(32'h0000_0003, 0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wb_inta_o) begin found = 1'b1; break; end
      @(negedge wb_clk);
    end
    check("vint_first", found, 1'b1);
    check("vint_with_vsync", vsync_pad_o, 1'b1);
    rd(12'h004, d); check("vint_stat", d, 32'd2);
    wr(12'h004, 32'h0000_0002);
    rd(12'h004, d); check("vint_cleared", d, 32'd0);
    check("vint_inta_cleared", wb_inta_o, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge wb_clk);
      if (wb_inta_o) begin found = 1'b1; break; end
    end
    check("vint_next_frame", found, 1'b1);
    check("vint_next_vsync", vsync_pad_o, 1'b1);
    wr(12'h004, 32'h0000_0002);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge wb_clk);
      if (wb_inta_o) found = 1'b1;
    end
    check("vint_once_per_frame", found, 1'b0);

    // Reset in the middle of a master read
    setup(32'h0000_0075, 40);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge wb_clk);
      if (wbm_cyc_o) begin found = 1'b1; break; end
    end
    check("midread_cyc_seen", found, 1'b1);
    repeat (5) @(negedge wb_clk);
    wb_rst = 1'b1;
    #1;
    check("midread_rst_master", {wbm_cyc_o, wbm_stb_o}, 2'b00);
    check("midread_rst_pads", {hsync_pad_o, vsync_pad_o, blank_pad_o, wb_inta_o}, 4'd0);
    check("midread_rst_rgb", {r_pad_o, g_pad_o, b_pad_o}, 24'd0);
    repeat (2) @(negedge wb_clk);
    wb_rst = 1'b0;
    rd(12'h000, d); check("midread_rst_ctrl", d, 32'd0);
    rd(12'h014, d); check("midread_rst_vbara", d, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
